// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Program-counter register and fetch sequencer for the single-issue datapath.
// The PC is presented to instruction memory (fetch_req/fetch_ack handshake)
// and to the external PC+4 adder. The next PC is picked from the adder result
// or the branch target. The block also provides a stall hold, a sticky
// misaligned-target trap, and a retired-instruction counter.
//
// Sequence: BOOT (1 cycle) -> FETCH (wait for ack) -> ADVANCE (pick next PC)
//           -> FETCH ...  A misaligned next PC parks the block in TRAP until
//           reset.
//
// Optional build macro: PCADDER_CHECK_EN
//   When defined, every unstalled ADVANCE cycle compares pc_plus4 against an
//   internally computed PC+4 and sets the sticky adder_mismatch flag on any
//   difference. When undefined, no comparator is built and adder_mismatch
//   is tied to 0.
//
// Parameters:
//   RESET_VECTOR   PC value loaded on reset
//   CNT_WIDTH      width of the retired-instruction counter
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   pc_plus4       in   [31:0] PC+4 returned by the PC adder
//   branch_target  in   [31:0] branch/jump target
//   branch_taken   in   selects branch_target (sampled in ADVANCE only)
//   stall          in   hold PC in ADVANCE (wins over branch_taken)
//   fetch_ack      in   instruction memory returned the word at PC
//   PC             out  [31:0] current program counter
//   fetch_req      out  fetch request for address PC
//   instr_valid    out  one-cycle pulse when the fetched word is valid
//   fault          out  sticky misaligned-target trap flag
//   retired_count  out  [CNT_WIDTH-1:0] number of PC advances since reset
//   adder_mismatch out  sticky adder consistency error
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          pc_plus4,
    input  logic [31:0]          branch_target,
    input  logic                 branch_taken,
    input  logic                 stall,
    input  logic                 fetch_ack,
    output logic [31:0]          PC,
    output logic                 fetch_req,
    output logic                 instr_valid,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic                 adder_mismatch
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        ADVANCE = 2'd2,
        TRAP    = 2'd3
    } state_t;

    state_t               state, state_d;
    logic [31:0]          pc_d;
    logic                 fetch_req_d;
    logic                 instr_valid_d;
    logic                 fault_d;
    logic [CNT_WIDTH-1:0] count_d;
    logic [31:0]          next_pc;

    // Candidate next PC; only acted on in an unstalled ADVANCE cycle.
    assign next_pc = branch_taken ? branch_target : pc_plus4;

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; without this the tool infers a latch.
        state_d       = state;
        pc_d          = PC;
        fetch_req_d   = fetch_req;
        instr_valid_d = 1'b0;
        fault_d       = fault;
        count_d       = retired_count;

        unique case (state)
            BOOT: begin
                state_d     = FETCH;
                fetch_req_d = 1'b1;
            end

            FETCH: begin
                // fetch_req is always high here, so any ack seen is genuine.
                if (fetch_ack) begin
                    fetch_req_d   = 1'b0;
                    instr_valid_d = 1'b1;
                    state_d       = ADVANCE;
                end
            end

            ADVANCE: begin
                if (!stall) begin
                    if (next_pc[1:0] != 2'b00) begin
                        // Misaligned target: freeze PC and counter, park.
                        fault_d = 1'b1;
                        state_d = TRAP;
                    end else begin
                        pc_d        = next_pc;
                        count_d     = retired_count + CNT_WIDTH'(1);
                        fetch_req_d = 1'b1;
                        state_d     = FETCH;
                    end
                end
            end

            TRAP: begin
                fetch_req_d = 1'b0;
            end

            default: state_d = TRAP;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= BOOT;
            PC            <= RESET_VECTOR;
            fetch_req     <= 1'b0;
            instr_valid   <= 1'b0;
            fault         <= 1'b0;
            retired_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement
            // order.
            state         <= state_d;
            PC            <= pc_d;
            fetch_req     <= fetch_req_d;
            instr_valid   <= instr_valid_d;
            fault         <= fault_d;
            retired_count <= count_d;
        end
    end

`ifdef PCADDER_CHECK_EN
    // Consistency check of the external adder. The check is separate from
    // the datapath: the PC update still takes pc_plus4 as delivered.
    logic adder_err;

    assign adder_err = (state == ADVANCE) && !stall && (pc_plus4 != PC + 32'd4);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            adder_mismatch <= 1'b0;
        end else if (adder_err) begin
            adder_mismatch <= 1'b1;
        end
    end
`else
    assign adder_mismatch = 1'b0;
`endif

endmodule
